rename_commit_queue: RTL and testbench

//  In-order retirement controller for the rename register file. Records every physical name
//  the rename file hands out, in allocation order; accepts out-of-order completion marks.

---
 rtl/rename_commit_queue_pkg.sv | 35 +++
 rtl/rename_commit_queue_if.sv | 40 ++++
 rtl/rcq_ring_ptr.sv | 38 +++
 rtl/rename_commit_queue.sv | 126 ++++++++++++
 tb/tb_rename_commit_queue.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/rename_commit_queue_pkg.sv
// ============================================================================
//  Module      : rename_commit_queue_pkg
//  Description : Shared constants and helpers for the rename commit queue
//                (default widths shared with the rename file, reset level,
//                tag-width helper).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rename_commit_queue_pkg;

    // Physical name width shared with the rename register file.
    localparam int c_name_width_default = 1;

    // Default number of in-flight entries.
    localparam int c_depth_default = 4;

    // Reset is asynchronous and asserted low.
    localparam logic c_rst_active = 1'b0;

    // ceil(log2(d)); the tag width needed to address d entries.
    function automatic int rcq_tag_w(input int d);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < d) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rename_commit_queue_if.sv
// ============================================================================
//  Module      : rename_commit_queue_if
//  Description : Allocation / completion / free bus between the pipeline,
//                the commit queue and the rename register file.
//                master = pipeline side, slave = commit queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rename_commit_queue_if
    import rename_commit_queue_pkg::*;
#(
    parameter int NAME_WIDTH = c_name_width_default,
    parameter int TAG_WIDTH  = rcq_tag_w(c_depth_default)
);
    logic                  ALLOC_E;
    logic [NAME_WIDTH-1:0] ALLOC_NAME;
    logic                  ALLOC_READY;
    logic [TAG_WIDTH-1:0]  ALLOC_TAG;
    logic                  DONE_E;
    logic [TAG_WIDTH-1:0]  DONE_TAG;
    logic                  FLUSH;
    logic                  FE;
    logic [NAME_WIDTH-1:0] FREE_NAME;
    logic [TAG_WIDTH:0]    COUNT;
    logic                  EMPTY;

    modport master (
        output ALLOC_E, ALLOC_NAME, DONE_E, DONE_TAG, FLUSH,
        input  ALLOC_READY, ALLOC_TAG, FE, FREE_NAME, COUNT, EMPTY
    );

    modport slave (
        input  ALLOC_E, ALLOC_NAME, DONE_E, DONE_TAG, FLUSH,
        output ALLOC_READY, ALLOC_TAG, FE, FREE_NAME, COUNT, EMPTY
    );

endinterface

`default_nettype wire

// File: rtl/rcq_ring_ptr.sv
// ============================================================================
//  Module      : rcq_ring_ptr
//  Description : Ring pointer for the commit queue. Increments mod 2**TAG_WIDTH,
//                synchronous clear, asynchronous active-low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rcq_ring_ptr
    import rename_commit_queue_pkg::*;
#(
    parameter int TAG_WIDTH = 2
) (
    input  wire logic                 CLK,
    input  wire logic                 RST,
    input  wire logic                 i_inc,
    input  wire logic                 i_clr,
    output logic      [TAG_WIDTH-1:0] o_ptr
);

    logic [TAG_WIDTH-1:0] r_ptr;

    // Pointer register; clear wins over increment, wrap is the natural overflow.
    always_ff @(posedge CLK or negedge RST) begin
        if (RST == c_rst_active) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/rename_commit_queue.sv
// ============================================================================
//  Module      : rename_commit_queue
//  Description : In-order retirement controller for the rename register file.
//                Records allocated physical names in order, accepts
//                out-of-order completion marks and frees one name per cycle,
//                oldest first. FLUSH discards everything without freeing.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rename_commit_queue
    import rename_commit_queue_pkg::*;
#(
    parameter int NAME_WIDTH = c_name_width_default,
    parameter int DEPTH      = c_depth_default,
    parameter int TAG_WIDTH  = rcq_tag_w(DEPTH)
) (
    input  wire logic           CLK,
    input  wire logic           RST,
    rename_commit_queue_if.slave bus
);

    localparam logic [TAG_WIDTH:0] c_depth = (TAG_WIDTH + 1)'(DEPTH);

    logic [NAME_WIDTH-1:0] r_name [DEPTH];
    logic [DEPTH-1:0]      r_valid;
    logic [DEPTH-1:0]      r_done;
    logic [TAG_WIDTH:0]    r_count;
    logic                  r_fe;
    logic [NAME_WIDTH-1:0] r_free_name;

    logic [TAG_WIDTH-1:0]  w_head;
    logic [TAG_WIDTH-1:0]  w_tail;
    logic                  w_ready;
    logic                  w_enq;
    logic                  w_head_done;
    logic                  w_retire;

    // Readiness looks only at the registered count, so a full queue refuses
    // allocation even in a cycle where it also retires.
    assign w_ready     = (r_count != c_depth);
    assign w_enq       = bus.ALLOC_E && w_ready && !bus.FLUSH;
    // Completion bypass lets a DONE on the head retire at the same edge.
    assign w_head_done = r_done[w_head] || (bus.DONE_E && (bus.DONE_TAG == w_head));
    assign w_retire    = r_valid[w_head] && w_head_done && !bus.FLUSH;

    rcq_ring_ptr #(.TAG_WIDTH(TAG_WIDTH)) u_head_ptr (
        .CLK   (CLK),
        .RST   (RST),
        .i_inc (w_retire),
        .i_clr (bus.FLUSH),
        .o_ptr (w_head)
    );

    rcq_ring_ptr #(.TAG_WIDTH(TAG_WIDTH)) u_tail_ptr (
        .CLK   (CLK),
        .RST   (RST),
        .i_inc (w_enq),
        .i_clr (bus.FLUSH),
        .o_ptr (w_tail)
    );

    // Entry state: completion marks first, then enqueue at tail, then retire at head.
    // Enqueue and retire never target the same slot (that would need a full queue).
    always_ff @(posedge CLK or negedge RST) begin
        if (RST == c_rst_active) begin
            r_valid <= '0;
            r_done  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_name[i] <= '0;
            end
        end else if (bus.FLUSH) begin
            r_valid <= '0;
            r_done  <= '0;
        end else begin
            if (bus.DONE_E && r_valid[bus.DONE_TAG]) begin
                r_done[bus.DONE_TAG] <= 1'b1;
            end
            if (w_enq) begin
                r_name[w_tail]  <= bus.ALLOC_NAME;
                r_valid[w_tail] <= 1'b1;
                r_done[w_tail]  <= 1'b0;
            end
            if (w_retire) begin
                r_valid[w_head] <= 1'b0;
                r_done[w_head]  <= 1'b0;
            end
        end
    end

    // Occupancy count; full and empty are told apart only by this.
    always_ff @(posedge CLK or negedge RST) begin
        if (RST == c_rst_active) begin
            r_count <= '0;
        end else if (bus.FLUSH) begin
            r_count <= '0;
        end else if (w_enq && !w_retire) begin
            r_count <= r_count + 1'b1;
        end else if (w_retire && !w_enq) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Registered free port; FREE_NAME holds its last value between pulses.
    always_ff @(posedge CLK or negedge RST) begin
        if (RST == c_rst_active) begin
            r_fe        <= 1'b0;
            r_free_name <= '0;
        end else if (w_retire) begin
            r_fe        <= 1'b1;
            r_free_name <= r_name[w_head];
        end else begin
            r_fe        <= 1'b0;
        end
    end

    assign bus.ALLOC_READY = w_ready;
    assign bus.ALLOC_TAG   = w_tail;
    assign bus.FE          = r_fe;
    assign bus.FREE_NAME   = r_free_name;
    assign bus.COUNT       = r_count;
    assign bus.EMPTY       = (r_count == '0);

endmodule

`default_nettype wire

// File: tb/tb_rename_commit_queue.sv
// ============================================================================
//  Module      : tb_rename_commit_queue
//  Description : Directed self-checking bench for rename_commit_queue
//                (NAME_WIDTH=4, DEPTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rename_commit_queue;

    localparam int c_nw = 4;
    localparam int c_tw = 2;

    logic CLK;
    logic RST;
    int   n_tests;
    int   n_fail;

    rename_commit_queue_if #(.NAME_WIDTH(c_nw), .TAG_WIDTH(c_tw)) bus ();

    rename_commit_queue #(.NAME_WIDTH(c_nw), .DEPTH(4), .TAG_WIDTH(c_tw)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ALLOC_E    = 1'b0;
        bus.ALLOC_NAME = '0;
        bus.DONE_E     = 1'b0;
        bus.DONE_TAG   = '0;
        bus.FLUSH      = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        RST = 1'b0;
        tick();
        RST = 1'b1;
    endtask

    task automatic alloc(input logic [c_nw-1:0] nm, input logic [c_tw-1:0] exp_tag, input string nm_s);
        bus.ALLOC_E = 1'b1; bus.ALLOC_NAME = nm;
        n_tests++;
        if (bus.ALLOC_TAG !== exp_tag) begin
            $display("FAIL %s ALLOC_TAG got %0d expected %0d", nm_s, bus.ALLOC_TAG, exp_tag); n_fail++;
        end
        tick();
        bus.ALLOC_E = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1'b0;
        #2;
        n_tests++; if (bus.ALLOC_READY !== 1'b1) begin $display("FAIL reset ALLOC_READY got %0b expected 1", bus.ALLOC_READY); n_fail++; end
        n_tests++; if (bus.ALLOC_TAG !== 2'd0) begin $display("FAIL reset ALLOC_TAG got %0d expected 0", bus.ALLOC_TAG); n_fail++; end
        n_tests++; if (bus.COUNT !== 3'd0) begin $display("FAIL reset COUNT got %0d expected 0", bus.COUNT); n_fail++; end
        n_tests++; if (bus.EMPTY !== 1'b1) begin $display("FAIL reset EMPTY got %0b expected 1", bus.EMPTY); n_fail++; end
        n_tests++; if (bus.FE !== 1'b0) begin $display("FAIL reset FE got %0b expected 0", bus.FE); n_fail++; end
        n_tests++; if (bus.FREE_NAME !== 4'd0) begin $display("FAIL reset FREE_NAME got %0d expected 0", bus.FREE_NAME); n_fail++; end
        tick();
        RST = 1'b1;
    endtask

    task automatic test_alloc();
        alloc(4'd5, 2'd0, "alloc0");
        n_tests++; if (bus.FE !== 1'b0) begin $display("FAIL alloc0 FE got %0b expected 0", bus.FE); n_fail++; end
        alloc(4'd6, 2'd1, "alloc1");
        alloc(4'd7, 2'd2, "alloc2");
        n_tests++; if (bus.COUNT !== 3'd3) begin $display("FAIL alloc COUNT got %0d expected 3", bus.COUNT); n_fail++; end
        n_tests++; if (bus.FE !== 1'b0) begin $display("FAIL alloc FE got %0b expected 0", bus.FE); n_fail++; end
        n_tests++; if (bus.EMPTY !== 1'b0) begin $display("FAIL alloc EMPTY got %0b expected 0", bus.EMPTY); n_fail++; end
    endtask

    task automatic test_out_of_order_done();
        logic [c_nw-1:0] exp_names [3];
        exp_names[0] = 4'd5; exp_names[1] = 4'd6; exp_names[2] = 4'd7;
        bus.DONE_E = 1'b1; bus.DONE_TAG = 2'd2;
        tick();
        n_tests++; if (bus.FE !== 1'b0) begin $display("FAIL ooo_done2 FE got %0b expected 0", bus.FE); n_fail++; end
        bus.DONE_TAG = 2'd1;
        tick();
        n_tests++; if (bus.FE !== 1'b0) begin $display("FAIL ooo_done1 FE got %0b expected 0", bus.FE); n_fail++; end
        bus.DONE_TAG = 2'd0;
        tick();
        bus.DONE_E = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (bus.FE !== 1'b1) begin $display("FAIL ooo_drain%0d FE got %0b expected 1", i, bus.FE); n_fail++; end
            n_tests++; if (bus.FREE_NAME !== exp_names[i]) begin $display("FAIL ooo_drain%0d FREE_NAME got %0d expected %0d", i, bus.FREE_NAME, exp_names[i]); n_fail++; end
            tick();
        end
        n_tests++; if (bus.FE !== 1'b0) begin $display("FAIL ooo_end FE got %0b expected 0", bus.FE); n_fail++; end
        n_tests++; if (bus.EMPTY !== 1'b1) begin $display("FAIL ooo_end EMPTY got %0b expected 1", bus.EMPTY); n_fail++; end
        n_tests++; if (bus.FREE_NAME !== 4'd7) begin $display("FAIL ooo_end FREE_NAME hold got %0d expected 7", bus.FREE_NAME); n_fail++; end
    endtask

    task automatic test_full_wrap();
        apply_reset();
        alloc(4'd1, 2'd0, "full_a0");
        alloc(4'd2, 2'd1, "full_a1");
        alloc(4'd3, 2'd2, "full_a2");
        alloc(4'd4, 2'd3, "full_a3");
        n_tests++; if (bus.ALLOC_READY !== 1'b0) begin $display("FAIL full ALLOC_READY got %0b expected 0", bus.ALLOC_READY); n_fail++; end
        n_tests++; if (bus.COUNT !== 3'd4) begin $display("FAIL full COUNT got %0d expected 4", bus.COUNT); n_fail++; end
        bus.ALLOC_E = 1'b1; bus.ALLOC_NAME = 4'd9;
        tick();
        n_tests++; if (bus.COUNT !== 3'd4) begin $display("FAIL full_refuse COUNT got %0d expected 4", bus.COUNT); n_fail++; end
        // Full queue still refuses while the head retires in the same cycle.
        bus.DONE_E = 1'b1; bus.DONE_TAG = 2'd0;
        tick();
        bus.DONE_E = 1'b0; bus.ALLOC_E = 1'b0;
        n_tests++; if (bus.FE !== 1'b1) begin $display("FAIL full_retire FE got %0b expected 1", bus.FE); n_fail++; end
        n_tests++; if (bus.FREE_NAME !== 4'd1) begin $display("FAIL full_retire FREE_NAME got %0d expected 1", bus.FREE_NAME); n_fail++; end
        n_tests++; if (bus.COUNT !== 3'd3) begin $display("FAIL full_retire COUNT got %0d expected 3", bus.COUNT); n_fail++; end
        n_tests++; if (bus.ALLOC_READY !== 1'b1) begin $display("FAIL full_retire ALLOC_READY got %0b expected 1", bus.ALLOC_READY); n_fail++; end
        alloc(4'd9, 2'd0, "wrap_alloc");
        n_tests++; if (bus.COUNT !== 3'd4) begin $display("FAIL wrap COUNT got %0d expected 4", bus.COUNT); n_fail++; end
        n_tests++; if (bus.FE !== 1'b0) begin $display("FAIL wrap FE got %0b expected 0", bus.FE); n_fail++; end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        alloc(4'd1, 2'd0, "b2b_a0");
        alloc(4'd2, 2'd1, "b2b_a1");
        bus.ALLOC_E = 1'b1; bus.ALLOC_NAME = 4'd3;
        bus.DONE_E  = 1'b1; bus.DONE_TAG = 2'd0;
        tick();
        idle_inputs();
        n_tests++; if (bus.COUNT !== 3'd2) begin $display("FAIL b2b COUNT got %0d expected 2", bus.COUNT); n_fail++; end
        n_tests++; if (bus.FE !== 1'b1) begin $display("FAIL b2b FE got %0b expected 1", bus.FE); n_fail++; end
        n_tests++; if (bus.FREE_NAME !== 4'd1) begin $display("FAIL b2b FREE_NAME got %0d expected 1", bus.FREE_NAME); n_fail++; end
        n_tests++; if (bus.ALLOC_TAG !== 2'd3) begin $display("FAIL b2b ALLOC_TAG got %0d expected 3", bus.ALLOC_TAG); n_fail++; end
        tick();
        n_tests++; if (bus.FE !== 1'b0) begin $display("FAIL b2b_after FE got %0b expected 0", bus.FE); n_fail++; end
    endtask

    task automatic test_done_invalid();
        apply_reset();
        bus.DONE_E = 1'b1; bus.DONE_TAG = 2'd0;
        tick();
        bus.DONE_E = 1'b0;
        n_tests++; if (bus.FE !== 1'b0) begin $display("FAIL inv_done FE got %0b expected 0", bus.FE); n_fail++; end
        alloc(4'd5, 2'd0, "inv_alloc");
        tick();
        n_tests++; if (bus.FE !== 1'b0) begin $display("FAIL inv_after FE got %0b expected 0", bus.FE); n_fail++; end
        n_tests++; if (bus.COUNT !== 3'd1) begin $display("FAIL inv_after COUNT got %0d expected 1", bus.COUNT); n_fail++; end
    endtask

    task automatic test_flush();
        apply_reset();
        alloc(4'd1, 2'd0, "fl_a0");
        alloc(4'd2, 2'd1, "fl_a1");
        alloc(4'd3, 2'd2, "fl_a2");
        bus.FLUSH = 1'b1; bus.DONE_E = 1'b1; bus.DONE_TAG = 2'd0;
        tick();
        idle_inputs();
        n_tests++; if (bus.FE !== 1'b0) begin $display("FAIL flush FE got %0b expected 0", bus.FE); n_fail++; end
        n_tests++; if (bus.COUNT !== 3'd0) begin $display("FAIL flush COUNT got %0d expected 0", bus.COUNT); n_fail++; end
        n_tests++; if (bus.EMPTY !== 1'b1) begin $display("FAIL flush EMPTY got %0b expected 1", bus.EMPTY); n_fail++; end
        alloc(4'd8, 2'd0, "flush_alloc");
        tick();
        n_tests++; if (bus.FE !== 1'b0) begin $display("FAIL flush_after FE got %0b expected 0", bus.FE); n_fail++; end
    endtask

    task automatic test_async_reset();
        apply_reset();
        alloc(4'd5, 2'd0, "ar_alloc");
        bus.DONE_E = 1'b1; bus.DONE_TAG = 2'd0;
        tick();
        bus.DONE_E = 1'b0;
        n_tests++; if (bus.FE !== 1'b1) begin $display("FAIL ar_pre FE got %0b expected 1", bus.FE); n_fail++; end
        #2 RST = 1'b0;
        #1;
        n_tests++; if (bus.FE !== 1'b0) begin $display("FAIL ar FE got %0b expected 0", bus.FE); n_fail++; end
        n_tests++; if (bus.FREE_NAME !== 4'd0) begin $display("FAIL ar FREE_NAME got %0d expected 0", bus.FREE_NAME); n_fail++; end
        #1 RST = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        RST     = 1'b0;
        idle_inputs();
        test_reset();
        test_alloc();
        test_out_of_order_done();
        test_full_wrap();
        test_back_to_back();
        test_done_invalid();
        test_flush();
        test_async_reset();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
